// File: rtl/regdump_pkg.sv
// Shared types and default sizes for the register-file dump reader.
package regdump_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive register range on the register-file read port and streams
// (index, value) pairs over valid/ready. Optional XOR checksum: REGDUMP_CHECKSUM_EN.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] FirstReg,
  input  logic [ADDR_WIDTH-1:0] LastReg,
  output logic [ADDR_WIDTH-1:0] ReadRegister,
  input  logic [DATA_WIDTH-1:0] ReadData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [ADDR_WIDTH-1:0] OutReg,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Checksum,
  output logic [1:0]            DbgState
);

  // Handshake: a word transfers on a rising edge where OutValid && OutReady;
  // OutValid never drops and OutReg/OutData never change until that happens.

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_reg_q, out_reg_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  start_acc;
  logic                  word_acc;

  assign start_acc = (state_q == IDLE) && Start;
  assign word_acc  = (state_q == HOLD) && OutReady;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_reg_d   = out_reg_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          cur_d   = FirstReg;
          last_d  = LastReg;
          busy_d  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        out_data_d  = ReadData;
        out_reg_d   = cur_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (OutReady) begin
          out_valid_d = 1'b0;
          if (cur_q == last_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            // Natural wrap at the top index gives the FirstReg > LastReg walk.
            cur_d   = cur_q + ADDR_WIDTH'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_reg_q   <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_reg_q   <= out_reg_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_acc) csum_d = '0;
    else if (word_acc) csum_d = csum_q ^ out_data_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign Checksum = csum_q;
`else
  logic unused_acc;
  assign unused_acc = start_acc ^ word_acc;
  assign Checksum   = '0;
`endif

  assign ReadRegister = cur_q;
  assign OutValid     = out_valid_q;
  assign OutReg       = out_reg_q;
  assign OutData      = out_data_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign DbgState     = state_q;

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out engine on the register file's read port. On a Start pulse it walks an inclusive register range, reads each register combinationally through its own read-address port, and streams (register number, value) pairs to a consumer over a valid/ready handshake. It sits beside the decode-stage read ports and gives the bench and the debug path a full architectural-state dump.

## Interface
Parameters:
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH registers)

Ports:
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Start  in  1  single-cycle request to begin a dump; ignored while Busy
- FirstReg  in  ADDR_WIDTH  first register index, latched on accepted Start
- LastReg  in  ADDR_WIDTH  last register index (inclusive), latched on accepted Start
- ReadRegister  out  ADDR_WIDTH  address to the register file read port
- ReadData  in  DATA_WIDTH  combinational register file read data
- OutValid  out  1  OutReg/OutData valid
- OutReady  in  1  consumer accepts when OutValid && OutReady
- OutReg  out  ADDR_WIDTH  index of the register being delivered
- OutData  out  DATA_WIDTH  value of that register
- Busy  out  1  high from the cycle after an accepted Start until Done
- Done  out  1  one-cycle pulse after the last word is accepted
- Checksum  out  DATA_WIDTH  XOR of all delivered words (see Configuration)

## Operation
- States: IDLE, READ, HOLD, DONE.
- IDLE: Start=1 → latch FirstReg/LastReg; current address cur=FirstReg; clear Checksum; go to READ.
- READ: ReadRegister=cur; at the clock edge capture ReadData→OutData and cur→OutReg; go to HOLD.
- HOLD: OutValid=1. On OutValid&&OutReady: XOR OutData into Checksum. If cur==LastReg go to DONE, else cur=cur+1 (mod 2^ADDR_WIDTH) and go to READ. Without the handshake, stay in HOLD with OutReg/OutData stable.
- DONE: Done=1 for one cycle, then IDLE.
- Range: FirstReg==LastReg gives exactly one word. FirstReg>LastReg wraps through the top index to 0, e.g. 30→1 gives 30, 31, 0, 1.
- Start while Busy: ignored, with no effect on the latched range.
- ReadRegister in IDLE/HOLD/DONE holds its last value (0 after reset).
- Concurrent register-file writes: each word reflects the register contents in its READ cycle. A dump is not an atomic snapshot.

## Timing
- Reset values: ReadRegister=0, OutValid=0, OutReg=0, OutData=0, Busy=0, Done=0, Checksum=0, state=IDLE.
- Rst_n asserted mid-dump: immediate return to IDLE with all outputs at reset values. No Done pulse.
- Start sampled at edge N → READ in cycle N+1 → OutValid high in cycle N+2.
- With OutReady held high: one word per 2 cycles. Accepting word k at edge M puts READ in cycle M+1 and the next OutValid in cycle M+2.
- Last accept at edge M → Done=1 in cycle M+1, Busy=0 from cycle M+2. A new Start is accepted from cycle M+2.
- All outputs are registered except ReadRegister, which is driven from the cur register.

## Configuration
- REGDUMP_CHECKSUM_EN defined: Checksum accumulates the XOR of every accepted OutData. It is cleared on an accepted Start and is stable and valid while Done=1 and until the next accepted Start.
- Not defined: no accumulator is built and Checksum is tied to 0. The port is present in both builds.

## Structure
- Shared package regdump_pkg holds the state enum (IDLE/READ/HOLD/DONE) and the default DATA_WIDTH/ADDR_WIDTH constants.
- Single module, no sub-module. The FSM, address counter, and output/checksum registers are small enough to keep flat.

## Test plan
- Registers 8..11 preloaded with 0x11,0x22,0x33,0x44; FirstReg=8, LastReg=11; OutReady=1 → four words (8,0x11)…(11,0x44) on alternate cycles, Done one cycle after the 4th accept, Checksum=0x44.
- FirstReg=LastReg=5, R5=0xDEADBEEF → exactly one word (5,0xDEADBEEF) followed by Done.
- FirstReg=30, LastReg=1 → OutReg sequence 30, 31, 0, 1. Word for register 0 has OutData=0.
- OutReady low for 5 cycles while OutValid is high → OutReg/OutData unchanged and no advance. Resumes on ready.
- Start pulsed again mid-dump with a different range → ignored; original range completes.
- Rst_n dropped during HOLD → OutValid, Busy, Checksum=0 immediately. Next Start gives a clean full dump.
